// File: rtl/mips_lsu_pkg.sv
// Shared types and helpers for the mips_cpu_lsu load/store unit.
// The LSU_ALIGN_CHECK_EN macro selects whether is_misaligned is used by the top.
package mips_lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  // Lane masks are positioned by a shift of 8*(3-offset): big-endian lanes.
  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  function automatic logic is_misaligned(lsu_op_t op, logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
// Big-endian: byte offset 0 is bits 31:24, half offset 0 is bits 31:16.
module mips_cpu_lsu_align
  import mips_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] wmerge
);

  lsu_op_t     op_e;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    op_e    = lsu_op_t'(op);
    // 3-off on two bits is ~off, so the lane shift is just the inverted offset.
    byte_sh = {~off, 3'b000};
    half_sh = {~off[1], 4'b0000};
    lane_b  = 8'(word >> byte_sh);
    lane_h  = 16'(word >> half_sh);
    rdata   = '0;
    wmerge  = word;
    case (op_e)
      OP_LB:  rdata = {{24{lane_b[7]}}, lane_b};
      OP_LBU: rdata = {24'h000000, lane_b};
      OP_LH:  rdata = {{16{lane_h[15]}}, lane_h};
      OP_LHU: rdata = {16'h0000, lane_h};
      OP_LW:  rdata = word;
      OP_SB:  wmerge = (word & ~(BYTE_MASK << byte_sh)) | ((wdata & BYTE_MASK) << byte_sh);
      OP_SH:  wmerge = (word & ~(HALF_MASK << half_sh)) | ((wdata & HALF_MASK) << half_sh);
      OP_SW:  wmerge = wdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: turns core requests into word-aligned data-port reads/writes,
// with read-modify-write for SB/SH. LSU_ALIGN_CHECK_EN enables misalignment errors.
module mips_cpu_lsu
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] data_address,
  output logic              data_write,
  output logic              data_read,
  output logic [DATA_W-1:0] data_writedata,
  input  logic [DATA_W-1:0] data_readdata
);

  lsu_state_t        state, next;
  lsu_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] word_q;
  logic              err_q;
  logic              accept;
  logic              mis;
  logic [31:0]       ext_rdata;
  logic [31:0]       merged;

  assign accept = req_valid && (state == S_IDLE);

`ifdef LSU_ALIGN_CHECK_EN
  assign mis = is_misaligned(lsu_op_t'(req_op), req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= OP_LB;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        op_q    <= lsu_op_t'(req_op);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= mis;
      end
      if (state == S_RD) word_q <= data_readdata;
    end
  end

  mips_cpu_lsu_align u_align (
    .op     (op_q),
    .off    (addr_q[1:0]),
    .word   (word_q),
    .wdata  (wdata_q),
    .rdata  (ext_rdata),
    .wmerge (merged)
  );

  always_comb begin
    next           = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    data_read      = 1'b0;
    data_write     = 1'b0;
    data_writedata = '0;
    data_address   = {addr_q[ADDR_W-1:2], 2'b00};
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (mis)                           next = S_DONE;
          else if (lsu_op_t'(req_op) == OP_SW) next = S_WR;
          else                               next = S_RD;
        end
      end
      S_RD: begin
        data_read = 1'b1;
        next      = (op_q == OP_SB || op_q == OP_SH) ? S_WR : S_DONE;
      end
      S_WR: begin
        data_write     = 1'b1;
        data_writedata = merged;
        next           = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = err_q ? '0 : ext_rdata;
        next       = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Scoreboard bench for mips_cpu_lsu with a behavioural data memory.
module tb_mips_cpu_lsu;
  import mips_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mem [0:15];
  int          n_checks = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          resp_cnt = 0;
  int          n0;

  always #5 clk = ~clk;

  mips_cpu_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  assign data_readdata = mem[data_address[5:2]];
  always @(posedge clk) if (data_write) mem[data_address[5:2]] <= data_writedata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      check("rw_overlap", {31'b0, data_read & data_write}, 32'd0);
      if (data_read) rd_cnt++;
      if (data_write) wr_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        if (sb.size() == 0) check("spurious_resp", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          check("rdata", resp_rdata, mon_e.rdata);
          check("err", {31'b0, resp_err}, {31'b0, mon_e.err});
          check("latency", cyc - mon_e.acc, mon_e.lat);
          check("done_strobes", {30'b0, data_read, data_write}, 32'd0);
        end
      end
    end
  end

  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat,
                         input int exp_rds, input int exp_wrs);
    exp_t e;
    int   base;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = lat;
    e.acc   = cyc + 1;
    sb.push_back(e);
    rd_cnt = 0;
    wr_cnt = 0;
    base   = resp_cnt;
    @(negedge clk); #1;
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10 && resp_cnt == base; i++) begin
      @(negedge clk); #1;
      check("ready_busy", {31'b0, req_ready}, 32'd0);
    end
    if (resp_cnt == base) check("resp_timeout", 32'd0, 32'd1);
    check("rd_strobes", rd_cnt, exp_rds);
    check("wr_strobes", wr_cnt, exp_wrs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'h80F17F01;
    mem[6] = 32'h11223344;
    mem[7] = 32'hA5A5A5A5;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_strobes", {30'b0, data_read, data_write}, 32'd0);
    check("rst_addr", data_address, 32'd0);
    check("rst_wdata", data_writedata, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    run_req(OP_LB,  32'h10, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0);
    run_req(OP_LB,  32'h11, 32'h0, 32'hFFFFFFF1, 1'b0, 2, 1, 0);
    run_req(OP_LB,  32'h13, 32'h0, 32'h00000001, 1'b0, 2, 1, 0);
    run_req(OP_LB,  32'h12, 32'h0, 32'h0000007F, 1'b0, 2, 1, 0);
    run_req(OP_LBU, 32'h10, 32'h0, 32'h00000080, 1'b0, 2, 1, 0);
    run_req(OP_LH,  32'h12, 32'h0, 32'h00007F01, 1'b0, 2, 1, 0);
    run_req(OP_LH,  32'h10, 32'h0, 32'hFFFF80F1, 1'b0, 2, 1, 0);
    run_req(OP_LHU, 32'h10, 32'h0, 32'h000080F1, 1'b0, 2, 1, 0);

    run_req(OP_SB, 32'h1A, 32'hFFFFFFAB, 32'h0, 1'b0, 3, 1, 1);
    check("mem_sb", mem[6], 32'h1122AB44);
    run_req(OP_SH, 32'h1E, 32'h12345566, 32'h0, 1'b0, 3, 1, 1);
    check("mem_sh", mem[7], 32'hA5A55566);
    run_req(OP_LW, 32'h18, 32'h0, 32'h1122AB44, 1'b0, 2, 1, 0);

    run_req(OP_SW, 32'h14, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1);
    check("mem_sw", mem[5], 32'hDEADBEEF);
    run_req(OP_LW, 32'h14, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);

    // Reset arrives while the SH is in its read cycle; no write or response may follow.
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = OP_SH;
    req_addr  = 32'h18;
    req_wdata = 32'h0000FFFF;
    n0 = resp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_rd", {31'b0, data_read}, 32'd1);
    @(negedge clk); #1;
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_strobes", {30'b0, data_read, data_write}, 32'd0);
    check("rst_mid_resp", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_noresp", resp_cnt, n0);
    check("rst_mid_mem", mem[6], 32'h1122AB44);

`ifdef LSU_ALIGN_CHECK_EN
    run_req(OP_LW, 32'h16, 32'h0, 32'h0, 1'b1, 1, 0, 0);
`else
    run_req(OP_LW, 32'h16, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
